// File: rtl/tube_p_r3_dma_if.sv
// Parasite-side bus bundle for the Tube register 3 transfer engine.
//   Tube side : p_nmi_b (ULA NMI, active low), p_cs_b, p_addr, p_rdnw, p_data_in, p_data_out
//   Memory    : mem_addr, mem_re, mem_rdata (valid the cycle after mem_re), mem_we, mem_wdata
// master = transfer engine, slave = Tube ULA / memory side.
interface tube_p_r3_dma_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              p_nmi_b;
  logic              p_cs_b;
  logic [2:0]        p_addr;
  logic              p_rdnw;
  logic [7:0]        p_data_in;
  logic [7:0]        p_data_out;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              mem_we;
  logic [7:0]        mem_wdata;

  modport master (
    input  p_nmi_b, p_data_in, mem_rdata,
    output p_cs_b, p_addr, p_rdnw, p_data_out, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    output p_nmi_b, p_data_in, mem_rdata,
    input  p_cs_b, p_addr, p_rdnw, p_data_out, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/tube_p_r3_dma.sv
// NMI-driven transfer engine between Tube register 3 (parasite address 5) and parasite memory.
// Each NMI moves one or two bytes (cfg_two_byte must match the ULA V flag).
//   p_phi2 / p_rst_b : clock (posedge) / asynchronous active-low reset
//   start, abort     : one-cycle control pulses; cfg_* latched on start
//   busy, done       : engine active / one-cycle completion (or abort) pulse
//   remaining        : bytes still to move
//   bus              : Tube + memory signals (tube_p_r3_dma_if.master)
// Optional: define TUBE_P_R3_DMA_IRQ_EN to add irq_b (sticky active-low completion
// interrupt) and irq_clr.
module tube_p_r3_dma #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              p_phi2,
  input  logic              p_rst_b,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              cfg_dir,
  input  logic              cfg_two_byte,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  remaining,
`ifdef TUBE_P_R3_DMA_IRQ_EN
  output logic              irq_b,
  input  logic              irq_clr,
`endif
  tube_p_r3_dma_if.master   bus
);

  typedef enum logic [3:0] {
    StIdle, StWait, StTubeRd, StMemWr, StMemRd, StMemWait, StTubeWr, StSettle, StFin
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic              dir_q, two_q, burst_q, abort_pend_q, done_q;
  logic              cs_b_q, rdnw_q, mem_re_q, mem_we_q;
  logic [2:0]        p_addr_q;
  logic [7:0]        data_out_q, mem_wdata_q;

  // Outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge p_phi2 or negedge p_rst_b) begin
    if (!p_rst_b) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rem_q        <= '0;
      dir_q        <= 1'b0;
      two_q        <= 1'b0;
      burst_q      <= 1'b0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      cs_b_q       <= 1'b1;
      rdnw_q       <= 1'b1;
      p_addr_q     <= 3'd0;
      data_out_q   <= 8'd0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 8'd0;
    end else begin
      done_q   <= 1'b0;
      cs_b_q   <= 1'b1;
      rdnw_q   <= 1'b1;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      // Abort outside WAIT/SETTLE waits here so an in-flight byte always finishes.
      if (abort && state_q != StIdle) abort_pend_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_count != '0) begin
              addr_q       <= cfg_addr;
              rem_q        <= cfg_count;
              dir_q        <= cfg_dir;
              two_q        <= cfg_two_byte;
              abort_pend_q <= 1'b0;
              state_q      <= StWait;
            end else begin
              rem_q  <= '0;
              done_q <= 1'b1;
            end
          end
        end
        StWait: begin
          if (abort || abort_pend_q) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end else if (!bus.p_nmi_b) begin
            burst_q <= 1'b0;
            if (dir_q) begin
              state_q  <= StMemRd;
              mem_re_q <= 1'b1;
            end else begin
              state_q  <= StTubeRd;
              cs_b_q   <= 1'b0;
              p_addr_q <= 3'd5;
            end
          end
        end
        StTubeRd: begin
          mem_wdata_q <= bus.p_data_in;
          mem_we_q    <= 1'b1;
          state_q     <= StMemWr;
        end
        StMemRd: state_q <= StMemWait;
        StMemWait: begin
          data_out_q <= bus.mem_rdata;
          cs_b_q     <= 1'b0;
          rdnw_q     <= 1'b0;
          p_addr_q   <= 3'd5;
          state_q    <= StTubeWr;
        end
        // Byte complete: the burst decision is folded into this edge so a byte costs
        // only its access cycles.
        StMemWr, StTubeWr: begin
          addr_q <= addr_q + ADDR_W'(1);
          rem_q  <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end else if (two_q && !burst_q) begin
            // Second byte of the burst goes without re-checking NMI.
            burst_q <= 1'b1;
            if (dir_q) begin
              state_q  <= StMemRd;
              mem_re_q <= 1'b1;
            end else begin
              state_q  <= StTubeRd;
              cs_b_q   <= 1'b0;
              p_addr_q <= 3'd5;
            end
          end else begin
            state_q <= StSettle;
          end
        end
        // One dead cycle lets the ULA's combinational NMI fall before it is sampled again.
        StSettle: begin
          if (abort || abort_pend_q) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end else begin
            state_q <= StWait;
          end
        end
        StFin: begin
          abort_pend_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef TUBE_P_R3_DMA_IRQ_EN
  logic irq_b_q;

  always_ff @(posedge p_phi2 or negedge p_rst_b) begin
    if (!p_rst_b)     irq_b_q <= 1'b1;
    else if (irq_clr) irq_b_q <= 1'b1;
    else if (done_q)  irq_b_q <= 1'b0;
  end

  assign irq_b = irq_b_q;
`endif

  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign remaining      = rem_q;
  assign bus.p_cs_b     = cs_b_q;
  assign bus.p_addr     = p_addr_q;
  assign bus.p_rdnw     = rdnw_q;
  assign bus.p_data_out = data_out_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_tube_p_r3_dma.sv
// Self-checking bench for tube_p_r3_dma: directed scenarios plus randomized transfers,
// checked against a byte-stream reference model (host bytes in order, memory image by
// address, one done per transfer).
module tb_tube_p_r3_dma;

  logic        clk, rst_n, start, abort, cfg_dir, cfg_two_byte, busy, done;
  logic [15:0] cfg_addr, cfg_count, remaining;
`ifdef TUBE_P_R3_DMA_IRQ_EN
  logic        irq_b, irq_clr;
`endif

  tube_p_r3_dma_if #(.ADDR_W(16)) bus ();

  tube_p_r3_dma #(.ADDR_W(16), .CNT_W(16)) dut (
    .p_phi2      (clk),
    .p_rst_b     (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_addr    (cfg_addr),
    .cfg_count   (cfg_count),
    .cfg_dir     (cfg_dir),
    .cfg_two_byte(cfg_two_byte),
    .busy        (busy),
    .done        (done),
    .remaining   (remaining),
`ifdef TUBE_P_R3_DMA_IRQ_EN
    .irq_b       (irq_b),
    .irq_clr     (irq_clr),
`endif
    .bus         (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rd_cnt   = 0;
  int cs_cnt   = 0;
  int re_cnt   = 0;
  int done_cnt = 0;
  int bad_addr = 0;
  int bad_idle = 0;

  logic [7:0]  host_bytes [256];  // host-side byte stream, indexed by Tube read number
  logic [7:0]  src_mem    [256];  // parasite memory image, indexed by address low byte
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [7:0]  tube_wr_data [$];
  int          tube_wr_cyc [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.p_data_in = host_bytes[rd_cnt[7:0]];

  // Bus monitor plus memory/ULA responder.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.mem_we) begin
        wr_addr_q.push_back(bus.mem_addr);
        wr_data_q.push_back(bus.mem_wdata);
      end
      if (bus.mem_re) begin
        re_cnt++;
        bus.mem_rdata <= src_mem[bus.mem_addr[7:0]];
      end
      if (!bus.p_cs_b) begin
        cs_cnt++;
        if (bus.p_addr != 3'd5) bad_addr++;
        if (bus.p_rdnw) rd_cnt <= rd_cnt + 1;
        else begin
          tube_wr_data.push_back(bus.p_data_out);
          tube_wr_cyc.push_back(cyc);
        end
      end else if (!bus.p_rdnw) begin
        bad_idle++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_result(input logic [15:0] a, input logic [15:0] cnt, input logic dir,
                              input int w0, input int t0, input int r0, input int d0,
                              input int c0);
    logic [15:0] ea;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("remaining", 64'(remaining), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("tube_accesses", 64'(cs_cnt - c0), 64'(cnt));
    if (dir) begin
      check("tube_writes", 64'(tube_wr_data.size() - t0), 64'(cnt));
      check("no_mem_writes", 64'(wr_addr_q.size() - w0), 64'd0);
      for (int i = 0; i < int'(cnt) && t0 + i < tube_wr_data.size(); i++) begin
        ea = a + 16'(i);
        check("tube_wdata", 64'(tube_wr_data[t0+i]), 64'(src_mem[ea[7:0]]));
      end
    end else begin
      check("mem_writes", 64'(wr_addr_q.size() - w0), 64'(cnt));
      check("no_tube_writes", 64'(tube_wr_data.size() - t0), 64'd0);
      for (int i = 0; i < int'(cnt) && w0 + i < wr_addr_q.size(); i++) begin
        ea = a + 16'(i);
        check("mem_waddr", 64'(wr_addr_q[w0+i]), 64'(ea));
        check("mem_wdata", 64'(wr_data_q[w0+i]), 64'(host_bytes[8'(r0+i)]));
      end
    end
  endtask

  task automatic pulse_start(input logic [15:0] a, input logic [15:0] cnt, input logic dir,
                             input logic two);
    @(negedge clk);
    cfg_addr = a; cfg_count = cnt; cfg_dir = dir; cfg_two_byte = two; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One NMI for a single-byte host-to-parasite burst; the Tube read must follow in 1 cycle.
  task automatic nmi_byte();
    bus.p_nmi_b = 1'b0;
    @(negedge clk);
    check("h2p_latency", 64'({bus.p_cs_b, bus.p_rdnw}), 64'(2'b01));
    bus.p_nmi_b = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_xfer(input logic [15:0] a, input logic [15:0] cnt, input logic dir,
                          input logic two, input bit rnd_nmi);
    int w0, t0, r0, d0, c0;
    bit fin;
    w0 = wr_addr_q.size(); t0 = tube_wr_data.size(); r0 = rd_cnt; d0 = done_cnt;
    c0 = cs_cnt;
    pulse_start(a, cnt, dir, two);
    fin = 1'b0;
    for (int k = 0; k < 2000 && !fin; k++) begin
      bus.p_nmi_b = rnd_nmi ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (done_cnt != d0) fin = 1'b1;
    end
    bus.p_nmi_b = 1'b1;
    repeat (2) @(negedge clk);
    check_result(a, cnt, dir, w0, t0, r0, d0, c0);
  endtask

  initial begin
    int w0, t0, r0, d0, c0, m0;
    bit busy_seen, fin;
    logic [15:0] ra, rc;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_addr = '0; cfg_count = '0; cfg_dir = 1'b0; cfg_two_byte = 1'b0;
    bus.p_nmi_b = 1'b1;
`ifdef TUBE_P_R3_DMA_IRQ_EN
    irq_clr = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      host_bytes[i] = 8'($urandom);
      src_mem[i]    = 8'($urandom);
    end
    host_bytes[0] = 8'hA5; host_bytes[1] = 8'h5A; host_bytes[2] = 8'hC3;
    src_mem[0] = 8'h11; src_mem[1] = 8'h22; src_mem[2] = 8'h33; src_mem[3] = 8'h44;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cs_b", 64'(bus.p_cs_b), 64'd1);
    check("rst_p_addr", 64'(bus.p_addr), 64'd0);
    check("rst_rdnw", 64'(bus.p_rdnw), 64'd1);
    check("rst_data_out", 64'(bus.p_data_out), 64'd0);
    check("rst_mem", 64'({bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'd0);
    check("rst_status", 64'({busy, done, remaining}), 64'd0);
`ifdef TUBE_P_R3_DMA_IRQ_EN
    check("rst_irq_b", 64'(irq_b), 64'd1);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 1: host-to-parasite, single byte per NMI
    w0 = wr_addr_q.size(); t0 = tube_wr_data.size(); r0 = rd_cnt; d0 = done_cnt;
    c0 = cs_cnt;
    pulse_start(16'h0400, 16'd3, 1'b0, 1'b0);
    repeat (3) nmi_byte();
    repeat (2) @(negedge clk);
    check_result(16'h0400, 16'd3, 1'b0, w0, t0, r0, d0, c0);
    if (wr_data_q.size() >= w0 + 3) begin
      check("t1_byte0", 64'(wr_data_q[w0]), 64'h A5);
      check("t1_byte1", 64'(wr_data_q[w0+1]), 64'h5A);
      check("t1_byte2", 64'(wr_data_q[w0+2]), 64'hC3);
    end

    // 2: parasite-to-host, two bytes per NMI, NMI held low
    t0 = tube_wr_data.size();
    run_xfer(16'h1000, 16'd4, 1'b1, 1'b1, 1'b0);
    if (tube_wr_cyc.size() >= t0 + 4) begin
      check("t2_in_pair0", 64'(tube_wr_cyc[t0+1] - tube_wr_cyc[t0]), 64'd3);
      check("t2_between", 64'(tube_wr_cyc[t0+2] - tube_wr_cyc[t0+1]), 64'd5);
      check("t2_in_pair1", 64'(tube_wr_cyc[t0+3] - tube_wr_cyc[t0+2]), 64'd3);
      check("t2_first", 64'(tube_wr_data[t0]), 64'h11);
      check("t2_last", 64'(tube_wr_data[t0+3]), 64'h44);
    end

    // 3: zero count
    w0 = wr_addr_q.size(); d0 = done_cnt; c0 = cs_cnt; m0 = re_cnt;
    @(negedge clk);
    cfg_count = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_done_next", 64'(done), 64'd1);
    busy_seen = busy;
    repeat (3) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    check("t3_busy_never", 64'(busy_seen), 64'd0);
    check("t3_done_once", 64'(done_cnt - d0), 64'd1);
    check("t3_no_bus", 64'((cs_cnt - c0) + (re_cnt - m0) + (wr_addr_q.size() - w0)), 64'd0);

    // 4: abort while waiting, after 2 of 5 bytes
    w0 = wr_addr_q.size(); d0 = done_cnt; c0 = cs_cnt;
    pulse_start(16'h2000, 16'd5, 1'b0, 1'b0);
    repeat (2) nmi_byte();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.p_nmi_b = 1'b0;
    repeat (10) @(negedge clk);
    bus.p_nmi_b = 1'b1;
    check("t4_done", 64'(done_cnt - d0), 64'd1);
    check("t4_remaining", 64'(remaining), 64'd3);
    check("t4_accesses", 64'(cs_cnt - c0), 64'd2);
    check("t4_writes", 64'(wr_addr_q.size() - w0), 64'd2);
    check("t4_busy", 64'(busy), 64'd0);

    // 5: reset during MEM_WAIT
    d0 = done_cnt;
    pulse_start(16'h3000, 16'd3, 1'b1, 1'b0);
    bus.p_nmi_b = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 50 && !fin; k++) begin
      @(negedge clk);
      if (bus.mem_re) fin = 1'b1;
    end
    check("t5_mem_re_seen", 64'(fin), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tube", 64'({bus.p_cs_b, bus.p_addr, bus.p_rdnw, bus.p_data_out}),
          64'({1'b1, 3'd0, 1'b1, 8'd0}));
    check("t5_rst_mem", 64'({bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'd0);
    check("t5_rst_status", 64'({busy, done, remaining}), 64'd0);
    bus.p_nmi_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    run_xfer(16'h3000, 16'd3, 1'b0, 1'b1, 1'b0);

    // 6: address wrap
    run_xfer(16'hFFFF, 16'd2, 1'b0, 1'b0, 1'b0);
`ifdef TUBE_P_R3_DMA_IRQ_EN
    check("t6_irq_low", 64'(irq_b), 64'd0);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("t6_irq_clr", 64'(irq_b), 64'd1);
`endif

    // Randomized transfers
    for (int n = 0; n < 24; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFA, 16'hFFFF))
                                       : 16'($urandom);
      rc = 16'($urandom_range(1, 6));
      run_xfer(ra, rc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    check("p_addr_always_5", 64'(bad_addr), 64'd0);
    check("rdnw_high_idle", 64'(bad_idle), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
